// File: rtl/fu_issue_queue_if.sv
// Dispatch-side and issue-side handshake bundle for fu_issue_queue.
// slave: the queue itself; master: the dispatch stage plus the function units.
interface fu_issue_queue_if #(
  parameter int WORD_W   = 32,
  parameter int NUM_FU   = 5,
  parameter int FU_IDX_W = 3
);
  logic                       disp_valid;
  logic                       disp_ready;
  logic [FU_IDX_W-1:0]        disp_fu_index;
  logic [WORD_W-1:0]          disp_data;
  logic                       disp_err;
  logic [NUM_FU-1:0]          iss_valid;
  logic [NUM_FU-1:0]          iss_ready;
  logic [NUM_FU*WORD_W-1:0]   iss_data;

  modport slave (
    input  disp_valid, disp_fu_index, disp_data, iss_ready,
    output disp_ready, disp_err, iss_valid, iss_data
  );

  modport master (
    output disp_valid, disp_fu_index, disp_data, iss_ready,
    input  disp_ready, disp_err, iss_valid, iss_data
  );
endinterface

// File: rtl/fu_issue_queue.sv
// Per-FU in-order issue queues fed by one dispatch port, one valid/ready issue port per FU.
// Optional zero-latency empty-queue bypass enabled by defining FU_ISSUE_BYPASS_EN.
module fu_issue_queue #(
  parameter int WORD_W   = 32,
  parameter int NUM_FU   = 5,
  parameter int DEPTH    = 4,
  parameter int FU_IDX_W = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                flush,
  fu_issue_queue_if.slave     q_if
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [WORD_W-1:0] mem_q [NUM_FU][DEPTH];
  ptr_t              wptr_q [NUM_FU];
  ptr_t              wptr_d [NUM_FU];
  ptr_t              rptr_q [NUM_FU];
  ptr_t              rptr_d [NUM_FU];
  cnt_t              cnt_q  [NUM_FU];
  cnt_t              cnt_d  [NUM_FU];
  logic              disp_err_q;

  logic              legal;
  logic [NUM_FU-1:0] tgt;
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] byp;
  logic [NUM_FU-1:0] enq;
  logic [NUM_FU-1:0] deq;

  assign legal = {1'b0, q_if.disp_fu_index} < (FU_IDX_W+1)'(NUM_FU);

  // One-hot target decode; a set bit always implies a legal index.
  always_comb begin
    tgt   = '0;
    full  = '0;
    empty = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      tgt[i]   = (q_if.disp_fu_index == FU_IDX_W'(i));
      full[i]  = (cnt_q[i] == CNT_W'(DEPTH));
      empty[i] = (cnt_q[i] == '0);
    end
  end

  // Illegal indices are always accepted so they drain; iss_ready is not consulted.
  assign q_if.disp_ready = !legal || |(tgt & ~full);

  always_comb begin
    byp = '0;
`ifdef FU_ISSUE_BYPASS_EN
    for (int i = 0; i < NUM_FU; i++)
      byp[i] = q_if.disp_valid & tgt[i] & empty[i] & q_if.iss_ready[i] & ~flush;
`endif
  end

  // Flush discards every handshake in its cycle.
  always_comb begin
    enq = '0;
    deq = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      enq[i] = q_if.disp_valid & tgt[i] & ~full[i] & ~byp[i] & ~flush;
      deq[i] = ~empty[i] & q_if.iss_ready[i] & ~flush;
    end
  end

  // NOTE: every next-state signal gets a default before any branch, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (flush) begin
        wptr_d[i] = '0;
        rptr_d[i] = '0;
        cnt_d[i]  = '0;
      end else begin
        if (enq[i]) wptr_d[i] = wptr_q[i] + PTR_W'(1);
        if (deq[i]) rptr_d[i] = rptr_q[i] + PTR_W'(1);
        case ({enq[i], deq[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
          2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  always_comb begin
    q_if.iss_valid = '0;
    q_if.iss_data  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      q_if.iss_valid[i] = ~empty[i] | byp[i];
      q_if.iss_data[i*WORD_W +: WORD_W] = byp[i] ? q_if.disp_data : mem_q[i][rptr_q[i]];
    end
  end

  assign q_if.disp_err = disp_err_q;

  // NOTE: storage is cleared on reset so iss_data reads 0 out of reset; state uses non-blocking updates only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      disp_err_q <= 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
        for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
      end
    end else begin
      disp_err_q <= q_if.disp_valid & ~legal;
      for (int i = 0; i < NUM_FU; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
        if (enq[i]) mem_q[i][wptr_q[i]] <= q_if.disp_data;
      end
    end
  end

endmodule

// File: doc/fu_issue_queue.md
Name: fu_issue_queue

Overview:
- Receiving end of the dispatch interface: accepts dispatch packets tagged with a function-unit index.
- Sorts each packet into a per-FU in-order FIFO.
- Issues packets to each FU over an independent valid/ready handshake.
- Sits between the dispatch stage and the scalar FUs (ALU, LD_ST, BRANCH) and the matrix FUs (LD_ST, GEMM).

Parameters:
- WORD_W, 32, width of the dispatched instruction payload.
- NUM_FU, 5, number of FU queues. Index map: 0 = scalar ALU, 1 = scalar LD_ST, 2 = BRANCH, 3 = matrix LD_ST, 4 = GEMM.
- DEPTH, 4, entries per FU queue; must be a power of two, at least 2.
- FU_IDX_W, 3, width of the FU index field in the dispatch packet.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- flush  in  1  clears all queues (mispredict/exception).
- disp_valid  in  1  dispatch packet valid.
- disp_ready  out  1  queue can accept the packet currently presented.
- disp_fu_index  in  FU_IDX_W  target FU of the packet.
- disp_data  in  WORD_W  instruction payload.
- disp_err  out  1  registered one-cycle pulse: a handshaked packet carried an index >= NUM_FU.
- iss_valid  out  NUM_FU  bit i: head of queue i is valid.
- iss_ready  in  NUM_FU  bit i: FU i accepts its head this cycle.
- iss_data  out  NUM_FU*WORD_W  slice i ([i*WORD_W +: WORD_W]) is the head payload of queue i.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset: all queues empty; read/write pointers and counts are 0.
  - iss_valid = 0, disp_err = 0, iss_data = 0 (storage is cleared).
  - RST has priority over every other input.
- Storage: per queue, DEPTH x WORD_W array, a write pointer, a read pointer and a count of width log2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
- disp_ready (combinational):
  - If disp_fu_index < NUM_FU: disp_ready = (count[disp_fu_index] < DEPTH).
  - Otherwise disp_ready = 1, so illegal packets drain.
  - A full queue does NOT accept a packet in the same cycle its head leaves. disp_ready does not depend on iss_ready.
- Enqueue: on disp_valid & disp_ready with a legal index:
  - write disp_data at wptr of the target queue;
  - wptr+1, count+1.
  - The packet is visible on iss_valid/iss_data the next cycle (1-cycle latency).
- Illegal index: on disp_valid & disp_ready with index >= NUM_FU:
  - the packet is dropped;
  - disp_err = 1 the following cycle, for one cycle only.
- Issue: iss_valid[i] = (count[i] != 0); iss_data slice i = entry at rptr[i].
  - On iss_valid[i] & iss_ready[i]: rptr[i]+1, count[i]-1.
  - iss_ready on an empty queue has no effect.
- Simultaneous enqueue and issue on the same queue: count unchanged, both pointers advance.
- Queues are fully independent. A stall on FU i never blocks dispatch to FU j unless j's queue is full.
- Ordering: strict FIFO per queue. No ordering is implied across queues.
- flush:
  - All counts and pointers return to 0 on the next edge.
  - Any enqueue or issue in the flush cycle is discarded. iss_valid still reflects the pre-flush state during that cycle, so FUs must ignore the handshake while flush is asserted.
  - disp_err is still generated for an illegal packet in the flush cycle.
- Reset asserted mid-operation: same as flush, plus disp_err and storage are cleared.

Optional Feature:
- Macro: FU_ISSUE_BYPASS_EN.
- Defined: zero-latency bypass when queue i is empty and iss_ready[i] = 1.
  - A legal dispatch to queue i drives iss_valid[i] = 1 and iss_data slice i = disp_data combinationally in the same cycle.
  - The packet is consumed without being written; count stays 0.
  - If iss_ready[i] = 0, the packet is enqueued normally.
  - Bypass is suppressed while flush = 1.
- Not defined: no bypass path. Minimum enqueue-to-issue latency is 1 cycle, and no combinational path exists from disp_* to iss_*.

Test Plan:
- Reset then idle: hold RST 2 cycles, release -> iss_valid = 5'b00000, disp_ready = 1 for every index 0..4, disp_err = 0.
- Single packet: dispatch index 4 with data 0xDEADBEEF, iss_ready = 0 -> next cycle iss_valid[4] = 1 and slice 4 = 0xDEADBEEF. Raise iss_ready[4] -> iss_valid[4] = 0 the following cycle.
- Full and ordering:
  - Dispatch 0x1..0x5 to index 0 with iss_ready[0] = 0 -> first 4 accepted; disp_ready = 0 on the 5th while index 0 is presented; disp_ready = 1 when index 2 is presented.
  - Then drain with iss_ready[0] = 1 -> outputs 0x1, 0x2, 0x3, 0x4 in order. Pointers wrap correctly on a second fill of 4.
- Simultaneous enqueue/issue: queue 1 holds 2 entries; dispatch 0xA to index 1 while iss_ready[1] = 1 -> count stays 2; head advances to the 2nd entry; 0xA is issued 2 pops later.
- Illegal index and flush:
  - Dispatch index 6 -> disp_ready = 1; disp_err = 1 for exactly one cycle; no iss_valid change.
  - Fill queues 0 and 3 with 2 entries each, assert flush with a concurrent dispatch to index 3 -> next cycle iss_valid = 0; the concurrent packet never appears.
- Bypass (FU_ISSUE_BYPASS_EN defined): queue 2 empty, iss_ready[2] = 1, dispatch 0x55 to index 2 -> iss_valid[2] = 1 with slice 2 = 0x55 in the same cycle; iss_valid[2] = 0 the next cycle.
  - Without the macro, the same stimulus shows 0x55 one cycle later.
